// File: rtl/br_predictor_pkg.sv
// Shared control definitions for the branch predictor: counter width default,
// counter init encodings, delay-slot offset and training action encoding.
package br_predictor_pkg;

  localparam int unsigned CNT_W_DEF = 2;

  // MIPS executes the delay slot, so the sequential successor is pc + 8.
  localparam logic [31:0] DELAY_SLOT_OFFSET = 32'd8;

  typedef enum logic [1:0] {
    TR_NONE,
    TR_UPDATE,
    TR_ALLOC,
    TR_INVAL
  } train_e;

  // Weakly-taken counter value: MSB set, all other bits clear.
  function automatic logic [3:0] cnt_weak_taken(input int unsigned w);
    return 4'(1 << (w - 1));
  endfunction

  // Weakly-not-taken counter value: MSB clear, all other bits set.
  function automatic logic [3:0] cnt_weak_not_taken(input int unsigned w);
    return 4'((1 << (w - 1)) - 1);
  endfunction

endpackage

// File: rtl/br_predictor_sat_counter.sv
// Saturating up/down counter next-state function (purely combinational).
module sat_counter #(
  parameter int unsigned CNT_W = 2
) (
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  // Step towards the requested direction, holding at either end.
  always_comb begin
    cnt_o = cnt_i;
    if (inc_i) begin
      if (cnt_i != '1) cnt_o = cnt_i + CNT_W'(1);
    end else begin
      if (cnt_i != '0) cnt_o = cnt_i - CNT_W'(1);
    end
  end

endmodule

// File: rtl/br_predictor.sv
// Dynamic branch predictor: direct-mapped BTB with saturating counters looked
// up in IF, prediction check and training in ID.
// Optional feature macro: BR_STATS_EN adds stat_br / stat_miss counters.
module br_predictor
  import br_predictor_pkg::*;
#(
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned TAG_W   = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        id_valid,
  input  logic        id_stall,
  input  logic [31:0] id_pc,
  input  logic        id_is_br,
  input  logic        id_pred_taken,
  input  logic [31:0] id_pred_target,
  input  logic        br_flag,
  input  logic [31:0] br_addr,
  output logic        mispredict,
  output logic [31:0] redirect_pc
`ifdef BR_STATS_EN
  ,
  output logic [31:0] stat_br,
  output logic [31:0] stat_miss
`endif
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(cnt_weak_taken(CNT_W));
  localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'(cnt_weak_not_taken(CNT_W));

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [CNT_W-1:0] cnt_q    [ENTRIES];

  logic [IDX_W-1:0] if_idx, id_idx;
  logic [TAG_W-1:0] if_tag, id_tag;
  logic             if_hit, id_hit, chk;
  logic [CNT_W-1:0] cnt_step;
  train_e           train;
  logic [TAG_W-1:0] tag_d;
  logic [31:0]      target_d;
  logic [CNT_W-1:0] cnt_d;
  logic             unused_pc;

  assign unused_pc = ^if_pc;

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign id_idx = id_pc[IDX_W+1:2];
  assign id_tag = id_pc[IDX_W+TAG_W+1:IDX_W+2];

  // IF lookup from registered tables; a same-cycle ID write is not bypassed.
  always_comb begin
    if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    pred_taken  = if_hit && cnt_q[if_idx][CNT_W-1];
    pred_target = if_hit ? target_q[if_idx] : '0;
  end

  // ID check; gating with rstn keeps mispredict low while reset is held.
  always_comb begin
    chk         = rstn && id_valid && !id_stall;
    mispredict  = 1'b0;
    redirect_pc = '0;
    if (chk) begin
      if (id_is_br)
        mispredict = (br_flag != id_pred_taken) ||
                     (br_flag && (id_pred_target != br_addr));
      else
        mispredict = id_pred_taken;
    end
    if (mispredict)
      redirect_pc = (br_flag && id_is_br) ? br_addr : id_pc + DELAY_SLOT_OFFSET;
  end

  sat_counter #(.CNT_W(CNT_W)) u_sat_counter (
    .cnt_i (cnt_q[id_idx]),
    .inc_i (br_flag),
    .cnt_o (cnt_step)
  );

  // Select the training action and the new entry contents for id_idx.
  always_comb begin
    id_hit   = valid_q[id_idx] && (tag_q[id_idx] == id_tag);
    train    = TR_NONE;
    tag_d    = tag_q[id_idx];
    target_d = target_q[id_idx];
    cnt_d    = cnt_q[id_idx];
    if (chk) begin
      if (id_is_br) begin
        if (id_hit) begin
          train = TR_UPDATE;
          cnt_d = cnt_step;
          if (br_flag) target_d = br_addr;
        end else if (br_flag) begin
          train    = TR_ALLOC;
          tag_d    = id_tag;
          target_d = br_addr;
          cnt_d    = CNT_WT;
        end
      end else if (id_hit) begin
        train = TR_INVAL;
      end
    end
  end

  // Table state: async clear, one entry written per trained cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= CNT_WNT;
      end
    end else begin
      case (train)
        TR_UPDATE: begin
          target_q[id_idx] <= target_d;
          cnt_q[id_idx]    <= cnt_d;
        end
        TR_ALLOC: begin
          valid_q[id_idx]  <= 1'b1;
          tag_q[id_idx]    <= tag_d;
          target_q[id_idx] <= target_d;
          cnt_q[id_idx]    <= cnt_d;
        end
        TR_INVAL: valid_q[id_idx] <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef BR_STATS_EN
  logic [31:0] stat_br_q, stat_br_d, stat_miss_q, stat_miss_d;

  // Saturating statistics next-state.
  always_comb begin
    stat_br_d   = stat_br_q;
    stat_miss_d = stat_miss_q;
    if (chk && id_is_br && (stat_br_q != '1)) stat_br_d = stat_br_q + 32'd1;
    if (mispredict && (stat_miss_q != '1))   stat_miss_d = stat_miss_q + 32'd1;
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_br_q   <= '0;
      stat_miss_q <= '0;
    end else begin
      stat_br_q   <= stat_br_d;
      stat_miss_q <= stat_miss_d;
    end
  end

  assign stat_br   = stat_br_q;
  assign stat_miss = stat_miss_q;
`else
  // No statistics counters in this build.
`endif

endmodule

// File: doc/br_predictor.md
# br_predictor

Parametrised dynamic branch predictor and resolution checker for the pipelined MIPS core. Looks up a direct-mapped branch target buffer (BTB) with saturating-counter history in IF, so fetch can be steered early. Checks the prediction carried down to ID against the actual outcome from the ID-stage branch judge, and trains its tables. It raises a same-cycle mispredict/redirect to the PC-select logic, and replaces the fixed "resolve in ID, always fetch sequentially" behaviour.

## Interface
Parameters:
- ENTRIES, 64, number of BTB/counter entries; power of two, 4..1024; IDX_W = log2(ENTRIES)
- CNT_W, 2, saturating-counter width, 1..4
- TAG_W, 8, stored tag width; IDX_W+TAG_W ≤ 30

Ports (reset is asynchronous, active-low, named rstn; single clock clk):
- clk  in  1  core clock, all state updates on rising edge
- rstn  in  1  asynchronous active-low reset
- if_pc  in  32  fetch-stage PC
- pred_taken  out  1  IF prediction: redirect fetch
- pred_target  out  32  IF predicted target
- id_valid  in  1  ID holds a real instruction
- id_stall  in  1  ID held this cycle; suppresses training and stats
- id_pc  in  32  ID-stage instruction PC
- id_is_br  in  1  ID instruction is any branch/jump (J, JAL, JR, JALR, BEQ, BNE, BLEZ, BGTZ, BLTZ, BGEZ)
- id_pred_taken  in  1  pred_taken piped from IF with this instruction
- id_pred_target  in  32  pred_target piped from IF
- br_flag  in  1  actual taken outcome from branch judge
- br_addr  in  32  actual target from branch judge
- mispredict  out  1  ID prediction wrong; flush and redirect
- redirect_pc  out  32  correct next fetch PC when mispredict=1

## Operation
- idx = pc[IDX_W+1:2]; tag = pc[IDX_W+TAG_W+1:IDX_W+2]. Entry = {valid, tag, target[31:0], cnt[CNT_W-1:0]}.
- Lookup (combinational from registered tables): hit = valid[idx] && tag match; pred_taken = hit && cnt[CNT_W-1]; pred_target = hit ? target[idx] : 0.
- Check, active when id_valid && !id_stall, else mispredict=0:
  - branch (id_is_br=1): mispredict = (br_flag != id_pred_taken) || (br_flag && id_pred_target != br_addr).
  - non-branch: mispredict = id_pred_taken (caused by aliasing).
- redirect_pc = br_flag && id_is_br ? br_addr : id_pc + 8. The delay slot is always executed; the sequential successor is id_pc+8. redirect_pc is 0 when mispredict=0.
- Train on rising edge when id_valid && !id_stall, using the id_pc index and tag:
  - branch, hit: cnt saturating +1 if br_flag, −1 otherwise, clamped to 0..2^CNT_W−1. If br_flag, target ← br_addr.
  - branch, miss, br_flag=1: allocate (overwrite). valid←1, tag, target←br_addr, cnt←2^(CNT_W−1), i.e. weakly taken.
  - branch, miss, br_flag=0: no change.
  - non-branch with hit: valid←0.
- Same-index IF read and ID write in one cycle: IF sees pre-write contents; there is no bypass.
- Address arithmetic is 32-bit modulo (id_pc+8 wraps at 2^32).

## Timing
- Lookup and check are zero-latency combinational. A training write is visible to lookups from the next cycle.
- Reset, asynchronous: all valid←0, all cnt←2^(CNT_W−1)−1 (weakly not-taken), all target←0, tags←0. Outputs during and after reset until a hit: pred_taken=0, pred_target=0, mispredict=0, redirect_pc=0.
- Reset asserted mid-operation discards any pending update; no partial write.
- id_stall=1 blocks training, so a held instruction trains exactly once, on its final unstalled cycle.

## Configuration
- BR_STATS_EN defined: adds outputs stat_br[31:0] and stat_miss[31:0]. stat_br increments on each trained branch; stat_miss increments on each checked cycle with mispredict=1. Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Shared control package/macro header, next to the existing control macros: CNT_W default, weak-taken/weak-not-taken init expressions, DELAY_SLOT_OFFSET = 8.
- One sub-module, sat_counter: a CNT_W-wide saturating up/down next-state function, instantiated per update path. The table arrays and the check logic stay in br_predictor.

## Test plan
- Reset then if_pc=0x0040_0010 → pred_taken=0, pred_target=0. Branch at that PC resolved with br_flag=1, br_addr=0x0040_0100 → mispredict=1, redirect_pc=0x0040_0100. Next cycle lookup → pred_taken=1, pred_target=0x0040_0100.
- Same branch trained not-taken twice (CNT_W=2): cnt goes 2→1→0. Then pred_taken=0. The first not-taken gives mispredict=1, redirect_pc=id_pc+8=0x0040_0018.
- Four consecutive taken outcomes: cnt saturates at 3 (no wrap to 0). One not-taken follows: cnt=2, and the prediction is still taken.
- JR hit predicting 0x1000 but br_addr=0x2000 → mispredict=1, redirect_pc=0x2000, stored target becomes 0x2000.
- Alias: a non-branch at a PC with matching idx/tag and id_pred_taken=1 → mispredict=1, redirect_pc=id_pc+8, entry invalidated. A stall held for 3 cycles on a branch → a single counter update.
- BR_STATS_EN: 5 branches with 2 mispredicts → stat_br=5, stat_miss=2. Preload near saturation → the counters hold at 0xFFFF_FFFF.
